dcache_2way: RTL and testbench
==============================

DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 Parameter ADDR_W, default 8, meaning CPU byte-address width (must be at least 4).
REQ-002 Parameter SET_BITS, default 2, meaning index width; the cache has 2**SET_BITS sets.
REQ-003 Parameter (derived) TAG_W = ADDR_W-2-SET_BITS, meaning tag width (must be at least 1).
REQ-004 Port clk, input, 1 bit, meaning the only clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 Port read, input, 1 bit, meaning CPU load request, held until busywait is low.
REQ-007 Port write, input, 1 bit, meaning CPU store request, held until busywait is low.
REQ-008 Port address, input, ADDR_W bits, meaning byte address, split as {tag, index, offset[1:0]}.
REQ-009 Port writedata, input, 8 bits, meaning store byte.
REQ-010 Port readdata, output, 8 bits, meaning load byte.
REQ-011 Port busywait, output, 1 bit, meaning stall the CPU while high.
REQ-012 Port mem_read, output, 1 bit, meaning memory block-fetch request.
REQ-013 Port mem_write, output, 1 bit, meaning memory block write-back request.
REQ-014 Port mem_address, output, ADDR_W-2 bits, meaning memory block address.
REQ-015 Port mem_writedata, output, 32 bits, meaning write-back block data.
REQ-016 Port mem_readdata, input, 32 bits, meaning fetched block data.
REQ-017 Port mem_busywait, input, 1 bit, meaning memory busy; low marks transfer complete.

Function
REQ-018 Organisation: 2-way set-associative, 4-byte blocks, write-back, write-allocate; per way and set the cache holds valid, dirty, tag and a 32-bit block; per set it holds one LRU bit naming the least-recently-used way.
REQ-019 Hit detection: combinational; a hit in way w requires valid[w][index] high and tag[w][index] equal to address tag; both ways hitting is impossible by construction.
REQ-020 Byte selection: offset 0..3 selects block bits [7:0], [15:8], [23:16] and [31:24] respectively, for both read and write.
REQ-021 Read hit: readdata is valid and busywait low in the same cycle, with zero stall cycles; at the next rising edge LRU[index] is set to point to the other way.
REQ-022 Write hit: busywait low in the same cycle; at the next rising edge the byte is written, dirty[w][index] is set to 1 and LRU is updated.
REQ-023 Victim choice on a miss: an invalid way is chosen if one exists, way 0 first; otherwise the way named by LRU[index] is chosen.
REQ-024 FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
REQ-025 IDLE transitions: on a miss with a dirty victim the FSM moves to WRITEBACK; on a miss with a clean victim it moves to FETCH; otherwise it stays in IDLE.
REQ-026 WRITEBACK outputs: mem_write=1, mem_address={victim tag, index}, mem_writedata=victim block; the FSM moves to FETCH on the first rising edge with mem_busywait low.
REQ-027 FETCH outputs: mem_read=1, mem_address={tag, index}; the FSM moves to UPDATE on the first rising edge with mem_busywait low.
REQ-028 UPDATE: in one cycle the victim is loaded with block=mem_readdata, valid=1, dirty=0 and tag=address tag, then the FSM returns to IDLE, where the request re-evaluates as a hit.
REQ-029 busywait: high in WRITEBACK, FETCH and UPDATE, and high in IDLE when read or write is asserted without a hit.
REQ-030 mem_read and mem_write: never high together; both low in IDLE and UPDATE.
REQ-031 Illegal request: read and write high together is ignored, with no state change, busywait low and no memory request.
REQ-032 Idle bus: with no request, readdata holds its last value and mem_address and mem_writedata are 0.
REQ-033 Address change: address or request changing outside IDLE is a protocol violation; the FSM completes using the values sampled on entry to the miss path.

Reset
REQ-034 On reset low (asynchronous): state=IDLE, all valid, dirty and LRU bits cleared, and busywait, mem_read and mem_write forced to 0 immediately, including mid-WRITEBACK or mid-FETCH.
REQ-035 Data and tag arrays are not required to be cleared.
REQ-036 Release: operation resumes on the first rising edge after reset returns high.

Verification
REQ-037 Cold read miss: after reset, read address 0x25, memory returns 0xDDCCBBAA after 3 busy cycles -> one FETCH with mem_address 0x09, then a hit with readdata 0xBB.
REQ-038 Write hit then read: write 0x5A to 0x27, then read 0x27 -> busywait never high, readdata 0x5A, dirty set.
REQ-039 Second way: read 0xA4 (same index as 0x24, different tag) -> a clean fetch fills way 1 and both blocks hit afterwards.
REQ-040 Dirty LRU eviction: with both ways full and LRU pointing at the dirty way from REQ-038, a read to a third tag -> WRITEBACK of the old block at its old address precedes FETCH.
REQ-041 Reset mid-FETCH: reset low during FETCH -> mem_read and busywait drop immediately, and a subsequent read of the same address misses.
REQ-042 Illegal request: read and write both high -> no memory activity and no array change.

Source files
------------

// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back, write-allocate byte cache with 4-byte blocks.
// Hits complete combinationally in IDLE; misses walk WRITEBACK/FETCH/UPDATE.
module dcache_2way #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SET_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [7:0]          writedata,
  output logic [7:0]          readdata,
  output logic                busywait,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_address,
  output logic [31:0]         mem_writedata,
  input  logic [31:0]         mem_readdata,
  input  logic                mem_busywait
);

  localparam int unsigned TAG_W = ADDR_W - 2 - SET_BITS;
  localparam int unsigned NSETS = 1 << SET_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH, S_UPDATE} state_t;

  state_t                state_q, state_d;
  logic [NSETS-1:0]      valid_q [2];
  logic [NSETS-1:0]      valid_d [2];
  logic [NSETS-1:0]      dirty_q [2];
  logic [NSETS-1:0]      dirty_d [2];
  logic [NSETS-1:0]      lru_q, lru_d;
  logic [TAG_W-1:0]      tag_q [2][NSETS];
  logic [TAG_W-1:0]      tag_d [2][NSETS];
  logic [31:0]           data_q [2][NSETS];
  logic [31:0]           data_d [2][NSETS];
  logic [7:0]            rdata_q, rdata_d;
  logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;
  logic [SET_BITS-1:0]   miss_idx_q, miss_idx_d;
  logic                  victim_q, victim_d;
  logic [31:0]           fill_q, fill_d;

  logic [TAG_W-1:0]      req_tag;
  logic [SET_BITS-1:0]   req_idx;
  logic [1:0]            req_off;
  logic                  req, hit0, hit1, hit, hit_way;
  logic                  victim_c, victim_dirty;
  logic [31:0]           hit_blk, wr_blk;
  logic [7:0]            hit_byte;
  logic                  busy_c, mem_read_c, mem_write_c;

  assign req_tag = address[ADDR_W-1 -: TAG_W];
  assign req_idx = address[2 +: SET_BITS];
  assign req_off = address[1:0];

  // Simultaneous read and write is treated as no request at all.
  assign req     = read ^ write;
  assign hit0    = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1    = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit     = req && (hit0 || hit1);
  assign hit_way = hit1;

  // Prefer an empty way (way 0 first), else evict the LRU way.
  assign victim_c     = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  assign victim_dirty = valid_q[victim_c][req_idx] && dirty_q[victim_c][req_idx];

  always_comb begin
    hit_blk  = hit1 ? data_q[1][req_idx] : data_q[0][req_idx];
    hit_byte = hit_blk[{req_off, 3'b000} +: 8];
    wr_blk   = hit_blk;
    wr_blk[{req_off, 3'b000} +: 8] = writedata;
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    lru_d         = lru_q;
    tag_d         = tag_q;
    data_d        = data_q;
    rdata_d       = rdata_q;
    miss_tag_d    = miss_tag_q;
    miss_idx_d    = miss_idx_q;
    victim_d      = victim_q;
    fill_d        = fill_q;
    busy_c        = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          lru_d[req_idx] = ~hit_way;
          if (read) begin
            rdata_d = hit_byte;
          end else begin
            data_d[hit_way][req_idx]  = wr_blk;
            dirty_d[hit_way][req_idx] = 1'b1;
          end
        end else if (req) begin
          busy_c     = 1'b1;
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          victim_d   = victim_c;
          state_d    = victim_dirty ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        busy_c        = 1'b1;
        mem_write_c   = 1'b1;
        mem_address   = {tag_q[victim_q][miss_idx_q], miss_idx_q};
        mem_writedata = data_q[victim_q][miss_idx_q];
        if (!mem_busywait) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy_c      = 1'b1;
        mem_read_c  = 1'b1;
        mem_address = {miss_tag_q, miss_idx_q};
        if (!mem_busywait) begin
          fill_d  = mem_readdata;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        busy_c                        = 1'b1;
        data_d[victim_q][miss_idx_q]  = fill_q;
        tag_d[victim_q][miss_idx_q]   = miss_tag_q;
        valid_d[victim_q][miss_idx_q] = 1'b1;
        dirty_d[victim_q][miss_idx_q] = 1'b0;
        state_d                       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs drop the instant reset goes low.
  assign busywait  = busy_c & reset;
  assign mem_read  = mem_read_c & reset;
  assign mem_write = mem_write_c & reset;
  assign readdata  = (state_q == S_IDLE && hit && read) ? hit_byte : rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      valid_q    <= '{default: '0};
      dirty_q    <= '{default: '0};
      lru_q      <= '0;
      rdata_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      victim_q   <= 1'b0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      lru_q      <= lru_d;
      rdata_q    <= rdata_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      victim_q   <= victim_d;
      fill_q     <= fill_d;
    end
  end

  // Tag and data storage carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way: a 3-busy-cycle block memory model, table of hit
// vectors, and hand-written miss, eviction, reset and illegal-request sequences.
module tb_dcache_2way;

  logic        clk = 1'b0;
  logic        reset, read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;

  int checks = 0;
  int errors = 0;

  dcache_2way #(.ADDR_W(8), .SET_BITS(2)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  // Block memory: busy for 3 cycles per request, completes on the 4th.
  logic [31:0] mem [64];
  int          cnt = 0;
  assign mem_busywait = (mem_read | mem_write) && (cnt != 3);
  assign mem_readdata = mem[mem_address];
  always @(posedge clk) begin
    if ((mem_read | mem_write) && cnt != 3) cnt <= cnt + 1;
    else cnt <= 0;
    if (mem_write && cnt == 3) mem[mem_address] <= mem_writedata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  int          a_stalls;
  logic        a_wb, a_fetch, a_order_bad, a_both, a_timeout;
  logic [5:0]  a_wb_addr, a_f_addr;
  logic [31:0] a_wb_data;
  logic [7:0]  a_rdata;

  // Apply one request, hold it until busywait is low, record memory traffic.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    a_stalls = 0; a_wb = 0; a_fetch = 0; a_order_bad = 0; a_both = 0; a_timeout = 1;
    a_wb_addr = '0; a_f_addr = '0; a_wb_data = '0; a_rdata = '0;
    @(posedge clk);
    #1 read = rd; write = wr; address = a; writedata = wd;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!busywait) begin
        a_rdata   = readdata;
        a_timeout = 0;
        break;
      end
      a_stalls++;
      if (mem_read && mem_write) a_both = 1;
      if (mem_write) begin
        if (a_fetch) a_order_bad = 1;
        a_wb = 1; a_wb_addr = mem_address; a_wb_data = mem_writedata;
      end
      if (mem_read) begin
        a_fetch = 1; a_f_addr = mem_address;
      end
    end
    @(posedge clk);
    #1 read = 0; write = 0;
  endtask

  task automatic check_miss(input string nm, input int stalls, input logic wb,
                            input logic [5:0] wba, input logic [31:0] wbd,
                            input logic [5:0] fa, input logic [7:0] rd);
    check({nm, "_timeout"}, 32'(a_timeout), 32'd0);
    check({nm, "_stalls"}, 32'(a_stalls), 32'(stalls));
    check({nm, "_wb_seen"}, 32'(a_wb), 32'(wb));
    if (wb) begin
      check({nm, "_wb_addr"}, 32'(a_wb_addr), 32'(wba));
      check({nm, "_wb_data"}, a_wb_data, wbd);
      check({nm, "_wb_before_fetch"}, 32'(a_order_bad), 32'd0);
    end
    check({nm, "_fetch_seen"}, 32'(a_fetch), 32'd1);
    check({nm, "_fetch_addr"}, 32'(a_f_addr), 32'(fa));
    check({nm, "_rd_wr_exclusive"}, 32'(a_both), 32'd0);
    check({nm, "_readdata"}, 32'(a_rdata), 32'(rd));
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       chk;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h09] = 32'hDDCCBBAA;
    mem[6'h29] = 32'h44332211;
    mem[6'h19] = 32'h88776655;
    mem[6'h04] = 32'h0F0E0D0C;

    // Hit vectors once set 1 holds tag 2 (way 0) and tag A (way 1).
    vecs[0] = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b1, 8'hAA};
    vecs[1] = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b1, 8'hBB};
    vecs[2] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b1, 8'hCC};
    vecs[3] = '{1'b1, 1'b0, 8'h27, 8'h00, 1'b1, 8'h5A};
    vecs[4] = '{1'b1, 1'b0, 8'hA4, 8'h00, 1'b1, 8'h11};
    vecs[5] = '{1'b1, 1'b0, 8'hA7, 8'h00, 1'b1, 8'h44};
    vecs[6] = '{1'b0, 1'b1, 8'hA6, 8'h99, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 8'hA6, 8'h00, 1'b1, 8'h99};
    vecs[8] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, 8'h22};

    reset = 0; read = 0; write = 0; address = '0; writedata = '0;
    #12;
    check("reset_busywait", 32'(busywait), 32'd0);
    check("reset_mem_req", 32'({mem_read, mem_write}), 32'd0);
    check("reset_mem_address", 32'(mem_address), 32'd0);
    check("reset_mem_writedata", mem_writedata, 32'd0);
    @(negedge clk);
    reset = 1;

    access(1'b1, 1'b0, 8'h25, 8'h00);
    check_miss("cold_read", 6, 1'b0, 6'h00, 32'h0, 6'h09, 8'hBB);

    access(1'b0, 1'b1, 8'h27, 8'h5A);
    check("wr_hit_stalls", 32'(a_stalls), 32'd0);
    access(1'b1, 1'b0, 8'h27, 8'h00);
    check("rd_after_wr_stalls", 32'(a_stalls), 32'd0);
    check("rd_after_wr_data", 32'(a_rdata), 32'h5A);

    access(1'b1, 1'b0, 8'hA4, 8'h00);
    check_miss("second_way", 6, 1'b0, 6'h00, 32'h0, 6'h29, 8'h11);

    for (int i = 0; i < 9; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d_stalls", i), 32'(a_stalls), 32'd0);
      if (vecs[i].chk) check($sformatf("vec%0d_readdata", i), 32'(a_rdata), 32'(vecs[i].exp_rd));
    end

    // LRU now names the dirty way 0; a third tag must write it back first.
    access(1'b1, 1'b0, 8'h64, 8'h00);
    check_miss("dirty_evict", 10, 1'b1, 6'h09, 32'h5ACCBBAA, 6'h19, 8'h55);
    check("evict_mem_image", mem[6'h09], 32'h5ACCBBAA);
    access(1'b1, 1'b0, 8'hA6, 8'h00);
    check("other_way_kept_stalls", 32'(a_stalls), 32'd0);
    check("other_way_kept_data", 32'(a_rdata), 32'h99);

    // Read and write together: hit address, then miss address.
    @(posedge clk);
    #1 read = 1; write = 1; address = 8'h64; writedata = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("illegal_hit_c%0d", c), 32'({busywait, mem_read, mem_write}), 32'd0);
    end
    #1 address = 8'h25;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("illegal_miss_c%0d", c), 32'({busywait, mem_read, mem_write}), 32'd0);
    end
    check("illegal_readdata_hold", 32'(readdata), 32'h99);
    @(posedge clk);
    #1 read = 0; write = 0;
    access(1'b1, 1'b0, 8'h64, 8'h00);
    check("post_illegal_stalls", 32'(a_stalls), 32'd0);
    check("post_illegal_data", 32'(a_rdata), 32'h55);
    access(1'b1, 1'b0, 8'h67, 8'h00);
    check("byte3_data", 32'(a_rdata), 32'h88);

    @(negedge clk);
    check("idle_readdata_hold", 32'(readdata), 32'h88);
    check("idle_mem_address", 32'(mem_address), 32'd0);
    check("idle_mem_writedata", mem_writedata, 32'd0);

    // Reset in the middle of a fetch.
    @(posedge clk);
    #1 read = 1; address = 8'h10;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_read) break;
    end
    check("midfetch_started", 32'(mem_read), 32'd1);
    #2 reset = 0;
    #1;
    check("midfetch_mem_read_drop", 32'(mem_read), 32'd0);
    check("midfetch_busywait_drop", 32'(busywait), 32'd0);
    read = 0;
    @(negedge clk);
    reset = 1;
    access(1'b1, 1'b0, 8'h10, 8'h00);
    check_miss("after_reset_same", 6, 1'b0, 6'h00, 32'h0, 6'h04, 8'h0C);
    access(1'b1, 1'b0, 8'h64, 8'h00);
    check_miss("after_reset_invalid", 6, 1'b0, 6'h00, 32'h0, 6'h19, 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
